// File: rtl/rename_reg_file_pkg.sv
// Shared widths, constants and the per-source read response for the rename register file.
package rename_reg_file_pkg;
  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int REG_AW = $clog2(REG_N);
  localparam int ROB_W  = 4;
  localparam int DP_W   = 2;
  localparam int CM_W   = 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef logic [REG_N-1:0][DATA_W-1:0] val_arr_t;
  typedef logic [REG_N-1:0][ROB_W-1:0]  tag_arr_t;

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
  } src_rsp_t;
endpackage

// File: rtl/rename_reg_file_if.sv
// Dispatch/commit/read bundle of the rename register file; lane k sits at index [k] of each packed bus.
interface rename_reg_file_if;
  import rename_reg_file_pkg::*;

  logic [DP_W-1:0]             dp_vld_in;
  logic [DP_W-1:0][REG_AW-1:0] dp_rs1_in;
  logic [DP_W-1:0][REG_AW-1:0] dp_rs2_in;
  logic [DP_W-1:0][REG_AW-1:0] dp_rd_in;
  logic [DP_W-1:0][ROB_W-1:0]  dp_rob_in;

  logic [DP_W-1:0]             rs1_busy_out;
  logic [DP_W-1:0][DATA_W-1:0] rs1_val_out;
  logic [DP_W-1:0][ROB_W-1:0]  rs1_rob_out;
  logic [DP_W-1:0]             rs2_busy_out;
  logic [DP_W-1:0][DATA_W-1:0] rs2_val_out;
  logic [DP_W-1:0][ROB_W-1:0]  rs2_rob_out;

  logic [CM_W-1:0]             cm_vld_in;
  logic [CM_W-1:0][REG_AW-1:0] cm_rd_in;
  logic [CM_W-1:0][DATA_W-1:0] cm_val_in;
  logic [CM_W-1:0][ROB_W-1:0]  cm_rob_in;
  logic                        flush_in;

  modport slave (
    input  dp_vld_in, dp_rs1_in, dp_rs2_in, dp_rd_in, dp_rob_in,
    input  cm_vld_in, cm_rd_in, cm_val_in, cm_rob_in, flush_in,
    output rs1_busy_out, rs1_val_out, rs1_rob_out,
    output rs2_busy_out, rs2_val_out, rs2_rob_out
  );

  modport master (
    output dp_vld_in, dp_rs1_in, dp_rs2_in, dp_rd_in, dp_rob_in,
    output cm_vld_in, cm_rd_in, cm_val_in, cm_rob_in, flush_in,
    input  rs1_busy_out, rs1_val_out, rs1_rob_out,
    input  rs2_busy_out, rs2_val_out, rs2_rob_out
  );
endinterface

// File: rtl/rename_reg_file_src_lookup.sv
// One source-operand read port: x0, older-lane rename forwarding, optional commit bypass, array read.
// RF_CMT_BYPASS_EN adds the same-cycle commit bypass.
module rf_src_lookup
  import rename_reg_file_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [REG_AW-1:0]           src,
  input  logic [DP_W-1:0]             dp_vld,
  input  logic [DP_W-1:0][REG_AW-1:0] dp_rd,
  input  logic [DP_W-1:0][ROB_W-1:0]  dp_rob,
`ifdef RF_CMT_BYPASS_EN
  input  logic [CM_W-1:0]             cm_vld,
  input  logic [CM_W-1:0][REG_AW-1:0] cm_rd,
  input  logic [CM_W-1:0][DATA_W-1:0] cm_val,
  input  logic [CM_W-1:0][ROB_W-1:0]  cm_rob,
`endif
  input  val_arr_t                    value,
  input  logic [REG_N-1:0]            busy,
  input  tag_arr_t                    tag,
  output src_rsp_t                    rsp
);

  // Later assignments override earlier ones, so the loops run oldest to youngest.
  always_comb begin
    rsp = '{busy: busy[src], val: value[src], rob: tag[src]};
`ifdef RF_CMT_BYPASS_EN
    for (int c = 0; c < CM_W; c++) begin
      if (cm_vld[c] && cm_rd[c] == src && cm_rob[c] == tag[src] && busy[src]) begin
        rsp.busy = FALSE;
        rsp.val  = cm_val[c];
      end
    end
`endif
    for (int j = 0; j < DP_W; j++) begin
      if (j < LANE && dp_vld[j] && dp_rd[j] == src && dp_rd[j] != REG_ZERO) begin
        rsp.busy = TRUE;
        rsp.rob  = dp_rob[j];
      end
    end
    if (src == REG_ZERO) rsp = '0;
  end

endmodule

// File: rtl/rename_reg_file.sv
// Multi-lane architectural register file with per-register busy bit and producer ROB tag.
// Optional RF_CMT_BYPASS_EN makes same-cycle commits visible to reads.
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  rename_reg_file_if.slave   rf
);

  val_arr_t         value_q, value_d;
  logic [REG_N-1:0] busy_q,  busy_d;
  tag_arr_t         tag_q,   tag_d;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (rdy_in) begin
      for (int c = 0; c < CM_W; c++) begin
        if (rf.cm_vld_in[c] && rf.cm_rd_in[c] != REG_ZERO)
          value_d[rf.cm_rd_in[c]] = rf.cm_val_in[c];
      end
      // Clear compares against the pre-update tag so a stale commit leaves a newer rename busy.
      for (int c = 0; c < CM_W; c++) begin
        if (rf.cm_vld_in[c] && rf.cm_rd_in[c] != REG_ZERO &&
            tag_q[rf.cm_rd_in[c]] == rf.cm_rob_in[c])
          busy_d[rf.cm_rd_in[c]] = FALSE;
      end
      if (rf.flush_in) begin
        busy_d = '0;
      end else begin
        for (int d = 0; d < DP_W; d++) begin
          if (rf.dp_vld_in[d] && rf.dp_rd_in[d] != REG_ZERO) begin
            tag_d[rf.dp_rd_in[d]]  = rf.dp_rob_in[d];
            busy_d[rf.dp_rd_in[d]] = TRUE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  src_rsp_t rs1_rsp [DP_W];
  src_rsp_t rs2_rsp [DP_W];

  for (genvar k = 0; k < DP_W; k++) begin : g_lane
    rf_src_lookup #(.LANE(k)) u_rs1 (
      .src    (rf.dp_rs1_in[k]),
      .dp_vld (rf.dp_vld_in),
      .dp_rd  (rf.dp_rd_in),
      .dp_rob (rf.dp_rob_in),
`ifdef RF_CMT_BYPASS_EN
      .cm_vld (rf.cm_vld_in),
      .cm_rd  (rf.cm_rd_in),
      .cm_val (rf.cm_val_in),
      .cm_rob (rf.cm_rob_in),
`endif
      .value  (value_q),
      .busy   (busy_q),
      .tag    (tag_q),
      .rsp    (rs1_rsp[k])
    );

    rf_src_lookup #(.LANE(k)) u_rs2 (
      .src    (rf.dp_rs2_in[k]),
      .dp_vld (rf.dp_vld_in),
      .dp_rd  (rf.dp_rd_in),
      .dp_rob (rf.dp_rob_in),
`ifdef RF_CMT_BYPASS_EN
      .cm_vld (rf.cm_vld_in),
      .cm_rd  (rf.cm_rd_in),
      .cm_val (rf.cm_val_in),
      .cm_rob (rf.cm_rob_in),
`endif
      .value  (value_q),
      .busy   (busy_q),
      .tag    (tag_q),
      .rsp    (rs2_rsp[k])
    );

    assign rf.rs1_busy_out[k] = rs1_rsp[k].busy;
    assign rf.rs1_val_out[k]  = rs1_rsp[k].val;
    assign rf.rs1_rob_out[k]  = rs1_rsp[k].rob;
    assign rf.rs2_busy_out[k] = rs2_rsp[k].busy;
    assign rf.rs2_val_out[k]  = rs2_rsp[k].val;
    assign rf.rs2_rob_out[k]  = rs2_rsp[k].rob;
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed scenarios then randomized traffic against a register-level reference model.
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rdy;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  logic [DATA_W-1:0] m_val  [REG_N];
  bit                m_busy [REG_N];
  logic [ROB_W-1:0]  m_tag  [REG_N];

  rename_reg_file_if rf_if();

  rename_reg_file dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .rf       (rf_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1;
    rdy   = 1'b1;
    rf_if.dp_vld_in = '0; rf_if.dp_rs1_in = '0; rf_if.dp_rs2_in = '0;
    rf_if.dp_rd_in  = '0; rf_if.dp_rob_in = '0;
    rf_if.cm_vld_in = '0; rf_if.cm_rd_in  = '0; rf_if.cm_val_in = '0;
    rf_if.cm_rob_in = '0; rf_if.flush_in  = 1'b0;
  endtask

  // Expected read for lane k: x0, then youngest older lane renaming s, then bypass, then storage.
  task automatic ref_read(input int k, input logic [REG_AW-1:0] s,
                          output logic b, output logic [DATA_W-1:0] v, output logic [ROB_W-1:0] r);
    b = m_busy[s]; v = m_val[s]; r = m_tag[s];
    if (s == 0) begin b = 0; v = 0; r = 0; return; end
    for (int j = k - 1; j >= 0; j--)
      if (rf_if.dp_vld_in[j] && rf_if.dp_rd_in[j] == s) begin
        b = 1; r = rf_if.dp_rob_in[j]; return;
      end
`ifdef RF_CMT_BYPASS_EN
    for (int c = CM_W - 1; c >= 0; c--)
      if (rf_if.cm_vld_in[c] && rf_if.cm_rd_in[c] == s && rf_if.cm_rob_in[c] == m_tag[s] && m_busy[s]) begin
        b = 0; v = rf_if.cm_val_in[c]; return;
      end
`endif
  endtask

  task automatic check_reads();
    logic b; logic [DATA_W-1:0] v; logic [ROB_W-1:0] r;
    for (int k = 0; k < DP_W; k++) begin
      ref_read(k, rf_if.dp_rs1_in[k], b, v, r);
      chk($sformatf("rs1_busy[%0d]", k), 64'(rf_if.rs1_busy_out[k]), 64'(b));
      if (b) chk($sformatf("rs1_rob[%0d]", k), 64'(rf_if.rs1_rob_out[k]), 64'(r));
      else   chk($sformatf("rs1_val[%0d]", k), 64'(rf_if.rs1_val_out[k]), 64'(v));
      ref_read(k, rf_if.dp_rs2_in[k], b, v, r);
      chk($sformatf("rs2_busy[%0d]", k), 64'(rf_if.rs2_busy_out[k]), 64'(b));
      if (b) chk($sformatf("rs2_rob[%0d]", k), 64'(rf_if.rs2_rob_out[k]), 64'(r));
      else   chk($sformatf("rs2_val[%0d]", k), 64'(rf_if.rs2_val_out[k]), 64'(v));
    end
  endtask

  // Register-level effect of one clock edge, youngest lane found first by scanning backwards.
  task automatic model_clk();
    logic [ROB_W-1:0] old_tag [REG_N];
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
      return;
    end
    if (!rdy) return;
    old_tag = m_tag;
    for (int i = 1; i < REG_N; i++) begin
      bit done_v = 0, hit_tag = 0, done_d = 0;
      for (int c = CM_W - 1; c >= 0; c--)
        if (rf_if.cm_vld_in[c] && rf_if.cm_rd_in[c] == i) begin
          if (!done_v) begin m_val[i] = rf_if.cm_val_in[c]; done_v = 1; end
          if (rf_if.cm_rob_in[c] == old_tag[i]) hit_tag = 1;
        end
      if (hit_tag) m_busy[i] = 0;
      if (rf_if.flush_in) m_busy[i] = 0;
      else
        for (int d = DP_W - 1; d >= 0; d--)
          if (!done_d && rf_if.dp_vld_in[d] && rf_if.dp_rd_in[d] == i) begin
            m_tag[i] = rf_if.dp_rob_in[d]; m_busy[i] = 1; done_d = 1;
          end
    end
  endtask

  task automatic tick();
    #1;
    if (chk_en) check_reads();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic dp(input int lane, input int rd, input int rob);
    rf_if.dp_vld_in[lane] = 1'b1;
    rf_if.dp_rd_in[lane]  = REG_AW'(rd);
    rf_if.dp_rob_in[lane] = ROB_W'(rob);
  endtask

  task automatic cm(input int lane, input int rd, input int rob, input int val);
    rf_if.cm_vld_in[lane] = 1'b1;
    rf_if.cm_rd_in[lane]  = REG_AW'(rd);
    rf_if.cm_rob_in[lane] = ROB_W'(rob);
    rf_if.cm_val_in[lane] = DATA_W'(val);
  endtask

  initial begin
    idle();
    @(negedge clk);
    // reset
    rst_n = 1'b0; tick(); rst_n = 1'b0; tick();
    chk_en = 1'b1;
    for (int r = 0; r < REG_N; r++) begin
      idle();
      rf_if.dp_rs1_in[0] = REG_AW'(r); rf_if.dp_rs2_in[1] = REG_AW'(r);
      #1;
      chk("rst_busy", 64'({rf_if.rs1_busy_out[0], rf_if.rs2_busy_out[1]}), 64'(0));
      chk("rst_val",  64'(rf_if.rs1_val_out[0] | rf_if.rs2_val_out[1]), 64'(0));
      chk("rst_rob",  64'(rf_if.rs1_rob_out[0] | rf_if.rs2_rob_out[1]), 64'(0));
      tick();
    end
    // rename then commit
    idle(); dp(0, 5, 3); tick();
    idle(); rf_if.dp_rs1_in[0] = 5; #1;
    chk("ren_busy", 64'(rf_if.rs1_busy_out[0]), 64'(1));
    chk("ren_rob",  64'(rf_if.rs1_rob_out[0]), 64'(3));
    cm(0, 5, 3, 32'hDEAD); tick();
    idle(); rf_if.dp_rs1_in[0] = 5; #1;
    chk("cmt_busy", 64'(rf_if.rs1_busy_out[0]), 64'(0));
    chk("cmt_val",  64'(rf_if.rs1_val_out[0]), 64'hDEAD);
    tick();
    // stale commit
    idle(); dp(0, 7, 1); tick();
    idle(); dp(0, 7, 2); tick();
    idle(); cm(0, 7, 1, 32'h11); tick();
    idle(); rf_if.dp_rs1_in[0] = 7; #1;
    chk("stale_val",  64'(rf_if.rs1_val_out[0]), 64'h11);
    chk("stale_busy", 64'(rf_if.rs1_busy_out[0]), 64'(1));
    chk("stale_rob",  64'(rf_if.rs1_rob_out[0]), 64'(2));
    tick();
    // in-bundle forwarding and x0
    idle(); dp(0, 9, 4); rf_if.dp_rs2_in[1] = 9; #1;
    chk("fwd_busy", 64'(rf_if.rs2_busy_out[1]), 64'(1));
    chk("fwd_rob",  64'(rf_if.rs2_rob_out[1]), 64'(4));
    tick();
    idle(); dp(0, 0, 7); rf_if.dp_rs1_in[1] = 0; #1;
    chk("x0_fwd_busy", 64'(rf_if.rs1_busy_out[1]), 64'(0));
    chk("x0_fwd_val",  64'(rf_if.rs1_val_out[1]), 64'(0));
    tick();
    idle(); rf_if.dp_rs1_in[0] = 0; #1;
    chk("x0_busy", 64'(rf_if.rs1_busy_out[0]), 64'(0));
    chk("x0_val",  64'(rf_if.rs1_val_out[0]), 64'(0));
    tick();
    // flush
    idle(); dp(0, 1, 1); dp(1, 2, 2); tick();
    idle(); dp(0, 3, 3); dp(1, 4, 4); tick();
    idle(); rf_if.flush_in = 1'b1; cm(0, 2, 10, 32'h55); dp(0, 3, 9); tick();
    idle();
    rf_if.dp_rs1_in[0] = 2; rf_if.dp_rs2_in[0] = 3; rf_if.dp_rs1_in[1] = 1; rf_if.dp_rs2_in[1] = 4; #1;
    chk("fl_busy", 64'({rf_if.rs1_busy_out, rf_if.rs2_busy_out}), 64'(0));
    chk("fl_val2", 64'(rf_if.rs1_val_out[0]), 64'h55);
    chk("fl_tag3", 64'(rf_if.rs2_rob_out[0]), 64'(3));
    tick();
    // commit bypass
    idle(); dp(0, 6, 5); tick();
    idle(); cm(0, 6, 5, 32'h77); rf_if.dp_rs1_in[0] = 6; #1;
`ifdef RF_CMT_BYPASS_EN
    chk("byp_busy", 64'(rf_if.rs1_busy_out[0]), 64'(0));
    chk("byp_val",  64'(rf_if.rs1_val_out[0]), 64'h77);
`else
    chk("byp_busy", 64'(rf_if.rs1_busy_out[0]), 64'(1));
    chk("byp_rob",  64'(rf_if.rs1_rob_out[0]), 64'(5));
`endif
    tick();
    idle(); rf_if.dp_rs1_in[0] = 6; #1;
    chk("byp_next_busy", 64'(rf_if.rs1_busy_out[0]), 64'(0));
    chk("byp_next_val",  64'(rf_if.rs1_val_out[0]), 64'h77);
    tick();
    // randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst_n = ($urandom_range(0, 99) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      rf_if.flush_in = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < DP_W; k++) begin
        rf_if.dp_vld_in[k] = $urandom_range(0, 1);
        rf_if.dp_rs1_in[k] = REG_AW'($urandom_range(0, 7));
        rf_if.dp_rs2_in[k] = REG_AW'($urandom_range(0, 7));
        rf_if.dp_rd_in[k]  = REG_AW'($urandom_range(0, 7));
        rf_if.dp_rob_in[k] = ROB_W'($urandom);
      end
      for (int c = 0; c < CM_W; c++) begin
        logic [REG_AW-1:0] rd;
        rd = REG_AW'($urandom_range(0, 7));
        rf_if.cm_vld_in[c] = $urandom_range(0, 1);
        rf_if.cm_rd_in[c]  = rd;
        rf_if.cm_val_in[c] = $urandom;
        rf_if.cm_rob_in[c] = $urandom_range(0, 2) != 0 ? m_tag[rd] : ROB_W'($urandom);
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
